bcd_serial_add_ctrl: RTL and testbench

//   Multi-digit packed-BCD adder sequencer. Time-shares one adder_4bit instance

---
 rtl/bcd_serial_add_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that walks the digits LSD first through one shared
// 4-bit binary adder, spending an ADD and a CORR (+6/+0) cycle on each digit.

module adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
  assign o_sum  = w_full[3:0];
  assign o_cout = w_full[4];
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_a_bcd,
  input  logic [4*DIGITS-1:0]   i_b_bcd,
  input  logic                  i_cin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_sum_bcd,
  output logic                  o_carry,
  output logic                  o_err
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int OPW   = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_CORR, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;

  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_creg;
  logic [3:0]       r_s;
  logic             r_c4;
  logic [OPW-1:0]   r_stage;
  logic [OPW-1:0]   r_sum;
  logic             r_carry;
  logic             r_err;

  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_dig;
  logic [3:0]       w_add_a;
  logic [3:0]       w_add_b;
  logic             w_add_cin;
  logic [3:0]       w_add_sum;
  logic             w_add_cout;
  logic             w_need_corr;
  logic             w_last;
  logic [OPW-1:0]   w_stage_next;

  function automatic logic has_bad_digit(input logic [OPW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    w_a_dig = 4'd0;
    w_b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_dig = r_a[4*i +: 4];
        w_b_dig = r_b[4*i +: 4];
      end
    end
  end

  assign w_need_corr = r_c4 | (r_s > 4'd9);
  assign w_last      = (r_idx == IDX_W'(DIGITS - 1));

  // Operand muxes for the single shared adder; quiet (all zero) outside ADD/CORR.
  always_comb begin
    w_add_a   = 4'd0;
    w_add_b   = 4'd0;
    w_add_cin = 1'b0;
    case (r_state)
      S_ADD: begin
        w_add_a   = w_a_dig;
        w_add_b   = w_b_dig;
        w_add_cin = r_creg;
      end
      S_CORR: begin
        w_add_a   = r_s;
        w_add_b   = w_need_corr ? 4'd6 : 4'd0;
        w_add_cin = 1'b0;
      end
      default: ;
    endcase
  end

  adder_4bit u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_comb begin
    w_stage_next = r_stage;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_stage_next[4*i +: 4] = w_add_sum;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ADD;
      S_ADD:   w_next = S_CORR;
      S_CORR:  w_next = w_last ? S_DONE : S_ADD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_DONE);
  end

  // Partial digits go to r_stage; the visible result only changes on entry to DONE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_creg  <= 1'b0;
      r_s     <= 4'd0;
      r_c4    <= 1'b0;
      r_stage <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_a_bcd;
            r_b     <= i_b_bcd;
            r_creg  <= i_cin;
            r_idx   <= '0;
            r_stage <= '0;
            r_err   <= has_bad_digit(i_a_bcd) | has_bad_digit(i_b_bcd);
          end
        end
        S_ADD: begin
          r_s  <= w_add_sum;
          r_c4 <= w_add_cout;
        end
        S_CORR: begin
          r_stage <= w_stage_next;
          r_creg  <= w_need_corr;
          if (w_last) begin
            r_sum   <= w_stage_next;
            r_carry <= w_need_corr;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sum_bcd = r_sum;
  assign o_carry   = r_carry;
  assign o_err     = r_err;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl: decimal reference model checked every
// cycle, plus literal expectations for the documented vectors (DIGITS=4 and 1).

module tb_bcd_serial_add_ctrl;
  localparam int D = 4;
  localparam int DONE_PH = 2 * D + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_cin = 1'b0;
  logic        o_busy, o_done, o_carry, o_err;
  logic [15:0] o_sum;

  logic        s1_start = 1'b0;
  logic [3:0]  s1_a = '0;
  logic [3:0]  s1_b = '0;
  logic        s1_cin = 1'b0;
  logic        o1_busy, o1_done, o1_carry, o1_err;
  logic [3:0]  o1_sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_a_bcd(i_a), .i_b_bcd(i_b),
    .i_cin(i_cin), .o_busy(o_busy), .o_done(o_done), .o_sum_bcd(o_sum),
    .o_carry(o_carry), .o_err(o_err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(s1_start), .i_a_bcd(s1_a), .i_b_bcd(s1_b),
    .i_cin(s1_cin), .o_busy(o1_busy), .o_done(o1_done), .o_sum_bcd(o1_sum),
    .o_carry(o1_carry), .o_err(o1_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal arithmetic on the operand values.
  function automatic logic bad_bcd(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    for (int i = 0; i < D; i++) begin
      if (t[3:0] > 4'd9) return 1'b1;
      t = t >> 4;
    end
    return 1'b0;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r, m;
    logic [15:0] t;
    r = 0; m = 1; t = v;
    for (int i = 0; i < D; i++) begin
      r = r + int'(t[3:0]) * m;
      m = m * 10;
      t = t >> 4;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    int t;
    r = '0; t = n;
    for (int i = 0; i < D; i++) begin
      r = r | (16'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  int          m_phase = 0;
  logic [15:0] m_sum = '0;
  logic        m_carry = 1'b0;
  logic        m_err = 1'b0;
  logic        m_known = 1'b1;
  logic [15:0] p_sum;
  logic        p_carry;
  logic        p_known;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_sum = '0; m_carry = 1'b0; m_err = 1'b0; m_known = 1'b1;
    end else if (m_phase == 0) begin
      if (i_start) begin
        int total;
        m_phase = 1;
        m_err   = bad_bcd(i_a) | bad_bcd(i_b);
        total   = bcd2int(i_a) + bcd2int(i_b) + int'(i_cin);
        p_sum   = int2bcd(total % 10000);
        p_carry = (total >= 10000);
        p_known = !m_err;
      end
    end else if (m_phase == DONE_PH - 1) begin
      m_phase = DONE_PH;
      m_sum   = p_sum;
      m_carry = p_carry;
      m_known = p_known;
    end else if (m_phase == DONE_PH) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_sum", 32'(o_sum), 32'd0);
    end else begin
      chk("busy", 32'(o_busy), 32'(m_phase != 0));
      chk("done", 32'(o_done), 32'(m_phase == DONE_PH));
      chk("err", 32'(o_err), 32'(m_err));
      if (m_known) begin
        chk("sum", 32'(o_sum), 32'(m_sum));
        chk("carry", 32'(o_carry), 32'(m_carry));
      end
    end
  end

  // Starts an operation; optionally pulses i_start with other operands in cycles 3 and 5.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input bit noise, output int done_cyc, output int ndone);
    @(negedge clk);
    i_start = 1'b1; i_a = a; i_b = b; i_cin = cin;
    @(posedge clk);
    done_cyc = -1;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (noise && (c == 3 || c == 5)) begin
        i_start = 1'b1; i_a = 16'h9999; i_b = 16'h9999; i_cin = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        ndone++;
        done_cyc = c;
        break;
      end
    end
    i_start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_res(input string name, input logic [15:0] s, input logic c, input logic e);
    chk({name, "_sum"}, 32'(o_sum), 32'(s));
    chk({name, "_carry"}, 32'(o_carry), 32'(c));
    chk({name, "_err"}, 32'(o_err), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd, c1;
    repeat (2) @(negedge clk);
    chk("reset_err", 32'(o_err), 32'd0);
    chk("reset_carry", 32'(o_carry), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op(16'h0123, 16'h0456, 1'b0, 1'b0, dc, nd);
    chk("t1_done_cycle", 32'(dc), 32'd9);
    expect_res("t1", 16'h0579, 1'b0, 1'b0);

    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, dc, nd);
    expect_res("t2a", 16'h0000, 1'b1, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b1, 1'b0, dc, nd);
    expect_res("t2b", 16'h9999, 1'b1, 1'b0);

    run_op(16'h0058, 16'h0067, 1'b0, 1'b0, dc, nd);
    expect_res("t3", 16'h0125, 1'b0, 1'b0);

    run_op(16'h00A3, 16'h0001, 1'b0, 1'b0, dc, nd);
    chk("t4_err", 32'(o_err), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, dc, nd);
    expect_res("t4b", 16'h0002, 1'b0, 1'b0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, dc, nd);
    chk("t5_done_cycle", 32'(dc), 32'd9);
    chk("t5_ndone", 32'(nd), 32'd1);
    expect_res("t5a", 16'h5555, 1'b0, 1'b0);
    run_op(16'h0500, 16'h0700, 1'b0, 1'b0, dc, nd);
    chk("t5_b2b_cycle", 32'(dc), 32'd9);
    expect_res("t5b", 16'h1200, 1'b0, 1'b0);

    // Abort with reset in cycle 4 of an operation.
    @(negedge clk);
    i_start = 1'b1; i_a = 16'h4444; i_b = 16'h1111; i_cin = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(o_busy), 32'd0);
    chk("t6_done", 32'(o_done), 32'd0);
    chk("t6_sum", 32'(o_sum), 32'd0);
    chk("t6_carry", 32'(o_carry), 32'd0);
    chk("t6_err", 32'(o_err), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_done) nd++;
    end
    chk("t6_no_done", 32'(nd), 32'd0);
    run_op(16'h0250, 16'h0750, 1'b1, 1'b0, dc, nd);
    chk("t6_done_cycle", 32'(dc), 32'd9);
    expect_res("t6b", 16'h1001, 1'b0, 1'b0);

    // Single-digit instance.
    @(negedge clk);
    s1_start = 1'b1; s1_a = 4'h8; s1_b = 4'h5; s1_cin = 1'b0;
    @(posedge clk);
    c1 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      s1_start = 1'b0;
      if (o1_done) begin
        c1 = c;
        break;
      end
    end
    chk("d1_done_cycle", 32'(c1), 32'd3);
    chk("d1_sum", 32'(o1_sum), 32'h3);
    chk("d1_carry", 32'(o1_carry), 32'd1);
    chk("d1_err", 32'(o1_err), 32'd0);
    @(negedge clk);
    chk("d1_idle_busy", 32'(o1_busy), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
